// File: rtl/uppmul.sv
// -----------------------------------------------------------------------------
// uppmul : unsigned sequential shift-add multiplier with fixed-point rescale.
//
// Converts a Q-format value back to integer scale:
//    p = min((a*b) >> FRAC, 2^PWIDTH-1)
// One multiplier bit is consumed per clock, LSB first. done rises BWIDTH+1
// clocks after the launching edge (or on the launching edge itself when an
// operand is zero) and is held until the next rising edge of start.
//
// Optional build macro: UPPMUL_ROUND_EN -> round-half-up before the shift
// (only meaningful for FRAC > 0; identical latency in both builds).
//
// Parameters:
//    AWIDTH : multiplicand width
//    BWIDTH : multiplier width, also the iteration count
//    FRAC   : fractional bits dropped from the full product
//    PWIDTH : output width; the shifted product saturates to this width
//
// Ports:
//    clk   in   rising-edge clock
//    rst   in   asynchronous active-high reset
//    start in   rising edge launches a multiply (a, b sampled on that edge)
//    a     in   AWIDTH multiplicand
//    b     in   BWIDTH multiplier
//    p     out  PWIDTH result, previous value kept while a multiply runs
//    done  out  result valid, held until the next start rising edge
//    ovf   out  shifted product did not fit in PWIDTH bits, p saturated
// -----------------------------------------------------------------------------
module uppmul #(
   parameter int AWIDTH = 32,
   parameter int BWIDTH = 16,
   parameter int FRAC   = 16,
   parameter int PWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AWIDTH-1:0] a,
   input  logic [BWIDTH-1:0] b,
   output logic [PWIDTH-1:0] p,
   output logic              done,
   output logic              ovf
);

   // Accumulator: upper AWIDTH+1 bits collect partial sums, lower BWIDTH bits
   // start out holding the multiplier and are shifted out as they are used.
   localparam int FW = AWIDTH + BWIDTH + 1;
   localparam int SW = (PWIDTH > FW) ? PWIDTH : FW;
   localparam int CW = $clog2(BWIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(BWIDTH);

`ifdef UPPMUL_ROUND_EN
   // Half an LSB of the result; zero when FRAC == 0.
   localparam logic [FW-1:0] RND = (FW'(1) << FRAC) >> 1;
`else
   localparam logic [FW-1:0] RND = '0;
`endif

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            r_state;
   logic              r_start_d;
   logic [CW-1:0]     r_cnt;
   logic [AWIDTH-1:0] r_a;
   logic [FW-1:0]     r_acc;

   logic              w_launch;
   logic              w_zero;
   logic [AWIDTH:0]   w_sum;
   logic [FW:0]       w_shift_full;
   logic [FW-1:0]     w_step;
   logic [FW-1:0]     w_rnd;
   logic [SW-1:0]     w_s;
   logic              w_ovf;
   logic [PWIDTH-1:0] w_p;

   assign w_launch = start & ~r_start_d;
   assign w_zero   = (a == '0) || (b == '0);

   // Add the multiplicand when the current multiplier bit (acc LSB) is set,
   // then shift the whole accumulator right by one.
   assign w_sum        = {1'b0, r_acc[AWIDTH+BWIDTH-1:BWIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
   assign w_shift_full = {1'b0, w_sum, r_acc[BWIDTH-1:0]};
   assign w_step       = w_shift_full[FW:1];

   // After BWIDTH steps the low AWIDTH+BWIDTH bits are the exact product and
   // the top bit is free to absorb the rounding carry.
   assign w_rnd = r_acc + RND;
   assign w_s   = SW'(w_rnd) >> FRAC;
   assign w_ovf = |(w_s >> PWIDTH);
   assign w_p   = w_ovf ? '1 : w_s[PWIDTH-1:0];

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_start_d <= 1'b0;
         r_cnt     <= '0;
         r_a       <= '0;
         r_acc     <= '0;
         p         <= '0;
         done      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         r_start_d <= start;
         if (w_launch) begin
            // A launch always wins, aborting any multiply in flight.
            r_a  <= a;
            done <= 1'b0;
            ovf  <= 1'b0;
            if (w_zero) begin
               r_acc   <= '0;
               r_cnt   <= '0;
               p       <= '0;
               done    <= 1'b1;
               r_state <= S_IDLE;
            end else begin
               // Cleared partial-sum half, multiplier loaded in the low half.
               r_acc   <= {{(AWIDTH+1){1'b0}}, b};
               r_cnt   <= CNT_LOAD;
               r_state <= S_RUN;
            end
         end else begin
            case (r_state)
               S_RUN: begin
                  if (r_cnt != '0) begin
                     r_acc <= w_step;
                     r_cnt <= r_cnt - CW'(1);
                  end else begin
                     p       <= w_p;
                     ovf     <= w_ovf;
                     done    <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
               S_IDLE: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uppmul.sv
// -----------------------------------------------------------------------------
// tb_uppmul : self-checking bench for uppmul. A default-parameter instance and
// a PWIDTH=16 instance share all inputs; both are compared against a plain
// arithmetic reference model after every multiply.
// -----------------------------------------------------------------------------
module tb_uppmul;

   localparam int FRAC = 16;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [15:0] b;
   logic [31:0] p;
   logic        done;
   logic        ovf;
   logic [15:0] p16;
   logic        done16;
   logic        ovf16;

   int total = 0;
   int bad   = 0;
   logic [31:0] last_p;
   logic        last_ovf;

   uppmul u_dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .p(p), .done(done), .ovf(ovf)
   );

   uppmul #(.AWIDTH(32), .BWIDTH(16), .FRAC(16), .PWIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .p(p16), .done(done16), .ovf(ovf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: exact product, optional half-LSB rounding, shift, saturate.
   function automatic logic [31:0] ref_p(input logic [31:0] av, input logic [15:0] bv,
                                         input int pw, output logic ov);
      logic [63:0] full;
      logic [63:0] s;
      logic [63:0] maxv;
      full = 64'(av) * 64'(bv);
`ifdef UPPMUL_ROUND_EN
      if (FRAC > 0) full = full + (64'd1 << (FRAC - 1));
`endif
      s    = full >> FRAC;
      maxv = (64'd1 << pw) - 64'd1;
      if (s > maxv) begin
         ov = 1'b1;
         return maxv[31:0];
      end
      ov = 1'b0;
      return s[31:0];
   endfunction

   // Compare both instances against the model for operands av/bv.
   task automatic chk_result(input string tag, input logic [31:0] av, input logic [15:0] bv);
      logic [31:0] e32;
      logic [31:0] e16;
      logic        o32;
      logic        o16;
      e32 = ref_p(av, bv, 32, o32);
      e16 = ref_p(av, bv, 16, o16);
      chk({tag, "_p"},      p, e32);
      chk({tag, "_ovf"},    {31'd0, ovf}, {31'd0, o32});
      chk({tag, "_done"},   {31'd0, done}, 32'd1);
      chk({tag, "_p16"},    {16'd0, p16}, e16);
      chk({tag, "_ovf16"},  {31'd0, ovf16}, {31'd0, o16});
      chk({tag, "_done16"}, {31'd0, done16}, 32'd1);
      last_p   = e32;
      last_ovf = o32;
   endtask

   // Wait (bounded) for done; returns the number of clocks after the launch edge.
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
   endtask

   // Full multiply: launch, check latency, check result.
   task automatic run_op(input string tag, input logic [31:0] av, input logic [15:0] bv);
      int n;
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk({tag, "_lat"}, n, (av == 32'd0 || bv == 16'd0) ? 32'd0 : 32'd17);
      chk_result(tag, av, bv);
   endtask

   // Outputs must stay frozen while inputs wiggle with start low.
   task automatic hold_chk(input string tag);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         a = $urandom;
         b = 16'($urandom);
         @(posedge clk);
         #1;
         chk({tag, "_hold_p"}, p, last_p);
         chk({tag, "_hold_done"}, {31'd0, done}, 32'd1);
         chk({tag, "_hold_ovf"}, {31'd0, ovf}, {31'd0, last_ovf});
      end
   endtask

   initial begin
      int n;
      logic [31:0] ra;
      logic [15:0] rb;
      rst   = 1'b1;
      start = 1'b0;
      a     = 32'd0;
      b     = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_p", p, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_done", {31'd0, done}, 32'd0);

      // Directed cases from the plan.
      run_op("one", 32'h0001_0000, 16'h1234);
      hold_chk("one");
      run_op("half", 32'h0000_8000, 16'd3);
      run_op("max", 32'hFFFF_FFFF, 16'hFFFF);
      run_op("sat16", 32'h0010_0000, 16'h1000);
      hold_chk("sat16");
      run_op("bzero", 32'hDEAD_BEEF, 16'd0);
      hold_chk("bzero");
      run_op("azero", 32'd0, 16'd5);

      // Restart mid-operation: first result (14) must never appear.
      run_op("pre", 32'h0003_0000, 16'd1);
      @(negedge clk);
      a = 32'h0002_0000;
      b = 16'd7;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
         chk("rs_stale_p", p, 32'd3);
      end
      a = 32'h0001_0000;
      b = 16'd9;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (p == 32'd14) chk("rs_never14", p, 32'd3);
      end
      chk("rs_lat", n, 32'd17);
      chk_result("rs", 32'h0001_0000, 16'd9);

      // Reset mid-multiply, then start held high through release.
      @(negedge clk);
      a = 32'h0003_0000;
      b = 16'd5;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_p", p, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_ovf", {31'd0, ovf}, 32'd0);
      a = 32'h0001_0000;
      b = 16'h0055;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      wait_done(n);
      chk("relaunch_lat", n, 32'd17);
      chk_result("relaunch", 32'h0001_0000, 16'h0055);
      start = 1'b0;

      // Randomized operands, with occasional zeros and large values.
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = 16'($urandom);
         if (i % 5 == 4) rb = 16'd0;
         if (i % 4 == 1) ra = ra >> 12;
         run_op("rand", ra, rb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
